popcount_dma_engine: RTL and testbench

Hardware popcount engine that replaces the software ARRAY->COUNT popcount loop run on the riscvsingle core. Driven by start/base/length inputs, it reads NUM words from a source array over a single-port word memory interface. For each word it counts the set bits, processing BPC bits per cycle with optional early exit, and writes the count to a destination array. It sits beside the core on the shared data memory and also exposes per-element and total cycle counters for performance comparison against the software loop.

---
 rtl/popcount_dma_engine.sv | 206 ++++++++++++++++++++
 tb/tb_popcount_dma_engine.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/popcount_dma_engine.sv
// Popcount offload engine: streams words from a source array over a single-port
// memory, counts set bits BPC at a time and writes each count to a destination array.
module popcount_dma_engine #(
    parameter  int DATA_W     = 32,
    parameter  int ADDR_W     = 32,
    parameter  int BPC        = 1,
    parameter  int EARLY_EXIT = 0,
    parameter  int LEN_W      = 16,
    parameter  int PERF_W     = 32,
    localparam int CNT_W      = $clog2(DATA_W + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [LEN_W-1:0]  num_elems,
    output logic              busy,
    output logic              done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [LEN_W-1:0]  elem_idx,
    output logic [CNT_W-1:0]  last_count,
    output logic [PERF_W-1:0] last_elem_cycles,
    output logic [PERF_W-1:0] total_cycles
);

    localparam int                BEATS     = DATA_W / BPC;
    localparam int                BEAT_W    = $clog2(BEATS + 1);
    localparam int                BYTES     = DATA_W / 8;
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(BYTES);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_REQ  = 3'd1,
        S_RD_WAIT = 3'd2,
        S_COUNT   = 3'd3,
        S_WR_REQ  = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t             state_r;
    logic [ADDR_W-1:0]  src_ptr_r;
    logic [ADDR_W-1:0]  dst_ptr_r;
    logic [LEN_W-1:0]   num_r;
    logic [DATA_W-1:0]  shift_r;
    logic [CNT_W-1:0]   acc_r;
    logic [BEAT_W-1:0]  beat_r;
    logic [PERF_W-1:0]  elem_cyc_r;

    logic [CNT_W-1:0]   acc_next_s;
    logic [DATA_W-1:0]  shift_next_s;
    logic               count_exit_s;
    logic               last_elem_s;
    logic [PERF_W-1:0]  elem_cyc_inc_s;
    logic [PERF_W-1:0]  total_inc_s;

    function automatic logic [CNT_W-1:0] popcount_slice(input logic [BPC-1:0] bits);
        logic [CNT_W-1:0] sum;
        sum = '0;
        for (int i = 0; i < BPC; i++) begin
            sum = sum + CNT_W'(bits[i]);
        end
        return sum;
    endfunction

    // Next-step datapath values and saturating counter increments
    always_comb begin
        acc_next_s   = acc_r + popcount_slice(shift_r[BPC-1:0]);
        shift_next_s = shift_r >> BPC;
        if (beat_r == LAST_BEAT) begin
            count_exit_s = 1'b1;
        end else if ((EARLY_EXIT != 0) && (shift_next_s == '0)) begin
            count_exit_s = 1'b1;
        end else begin
            count_exit_s = 1'b0;
        end
        last_elem_s = ((elem_idx + LEN_W'(1)) == num_r);
        if (elem_cyc_r == '1) begin
            elem_cyc_inc_s = elem_cyc_r;
        end else begin
            elem_cyc_inc_s = elem_cyc_r + PERF_W'(1);
        end
        if (total_cycles == '1) begin
            total_inc_s = total_cycles;
        end else begin
            total_inc_s = total_cycles + PERF_W'(1);
        end
    end

    // Job sequencer with registered memory-port and status outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r          <= S_IDLE;
            busy             <= 1'b0;
            done             <= 1'b0;
            mem_req          <= 1'b0;
            mem_we           <= 1'b0;
            mem_addr         <= '0;
            mem_wdata        <= '0;
            elem_idx         <= '0;
            last_count       <= '0;
            last_elem_cycles <= '0;
            total_cycles     <= '0;
            src_ptr_r        <= '0;
            dst_ptr_r        <= '0;
            num_r            <= '0;
            shift_r          <= '0;
            acc_r            <= '0;
            beat_r           <= '0;
            elem_cyc_r       <= '0;
        end else begin
            done <= 1'b0;
            if (busy) begin
                total_cycles <= total_inc_s;
                elem_cyc_r   <= elem_cyc_inc_s;
            end
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        src_ptr_r    <= src_base;
                        dst_ptr_r    <= dst_base;
                        num_r        <= num_elems;
                        elem_idx     <= '0;
                        total_cycles <= '0;
                        if (num_elems == '0) begin
                            state_r <= S_DONE;
                            done    <= 1'b1;
                        end else begin
                            state_r    <= S_RD_REQ;
                            busy       <= 1'b1;
                            mem_req    <= 1'b1;
                            mem_we     <= 1'b0;
                            mem_addr   <= src_base;
                            elem_cyc_r <= '0;
                        end
                    end
                end
                S_RD_REQ: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        state_r <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    if (mem_rvalid) begin
                        shift_r <= mem_rdata;
                        acc_r   <= '0;
                        beat_r  <= '0;
                        state_r <= S_COUNT;
                    end
                end
                S_COUNT: begin
                    acc_r   <= acc_next_s;
                    shift_r <= shift_next_s;
                    beat_r  <= beat_r + BEAT_W'(1);
                    if (count_exit_s) begin
                        state_r   <= S_WR_REQ;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= dst_ptr_r;
                        mem_wdata <= DATA_W'(acc_next_s);
                    end
                end
                S_WR_REQ: begin
                    if (mem_gnt) begin
                        mem_req          <= 1'b0;
                        mem_we           <= 1'b0;
                        last_count       <= acc_r;
                        // elem_cyc_r has not yet counted this grant cycle
                        last_elem_cycles <= elem_cyc_inc_s;
                        elem_idx         <= elem_idx + LEN_W'(1);
                        src_ptr_r        <= src_ptr_r + ADDR_STEP;
                        dst_ptr_r        <= dst_ptr_r + ADDR_STEP;
                        if (last_elem_s) begin
                            state_r <= S_DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            state_r    <= S_RD_REQ;
                            mem_req    <= 1'b1;
                            mem_addr   <= src_ptr_r + ADDR_STEP;
                            elem_cyc_r <= '0;
                        end
                    end
                end
                S_DONE: begin
                    state_r <= S_IDLE;
                end
                default: begin
                    state_r <= S_IDLE;
                    busy    <= 1'b0;
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_popcount_dma_engine.sv
// Directed bench for popcount_dma_engine: three instances (default, early exit,
// BPC=4) share one behavioural memory responder selected by sel.
module tb_popcount_dma_engine;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  start_v = 3'b000;
    logic [31:0] src_base = 32'h0;
    logic [31:0] dst_base = 32'h0;
    logic [15:0] num_elems = 16'h0;
    logic [1:0]  sel = 2'd0;

    logic        gnt = 1'b0;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = 32'h0;

    logic        busy_a [3];
    logic        done_a [3];
    logic        req_a  [3];
    logic        we_a   [3];
    logic        gnt_a  [3];
    logic [31:0] addr_a [3];
    logic [31:0] wdata_a[3];
    logic [15:0] idx_a  [3];
    logic [5:0]  lc_a   [3];
    logic [31:0] lec_a  [3];
    logic [31:0] tot_a  [3];

    always #5 clk = ~clk;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        assign gnt_a[k] = gnt && (int'(sel) == k);
        popcount_dma_engine #(
            .BPC        ((k == 2) ? 4 : 1),
            .EARLY_EXIT ((k == 1) ? 1 : 0)
        ) u_dut (
            .clk              (clk),
            .reset            (reset),
            .start            (start_v[k]),
            .src_base         (src_base),
            .dst_base         (dst_base),
            .num_elems        (num_elems),
            .busy             (busy_a[k]),
            .done             (done_a[k]),
            .mem_req          (req_a[k]),
            .mem_we           (we_a[k]),
            .mem_addr         (addr_a[k]),
            .mem_wdata        (wdata_a[k]),
            .mem_gnt          (gnt_a[k]),
            .mem_rvalid       (rvalid && (int'(sel) == k)),
            .mem_rdata        (rdata),
            .elem_idx         (idx_a[k]),
            .last_count       (lc_a[k]),
            .last_elem_cycles (lec_a[k]),
            .total_cycles     (tot_a[k])
        );
    end

    logic        m_req, m_we, m_busy, m_done;
    logic [31:0] m_addr, m_wdata, m_lec, m_tot;
    logic [15:0] m_idx;
    logic [5:0]  m_lc;
    assign m_req   = req_a[sel];
    assign m_we    = we_a[sel];
    assign m_busy  = busy_a[sel];
    assign m_done  = done_a[sel];
    assign m_addr  = addr_a[sel];
    assign m_wdata = wdata_a[sel];
    assign m_lec   = lec_a[sel];
    assign m_tot   = tot_a[sel];
    assign m_idx   = idx_a[sel];
    assign m_lc    = lc_a[sel];

    int tests = 0;
    int fails = 0;

    logic [31:0] mem [0:255];
    logic [31:0] src_words [20];
    int          exp_cnt [20];
    int          stall_max = 0;

    // responder state and write log
    int          wr_n = 0;
    logic [31:0] wa_log  [256];
    logic [31:0] wd_log  [256];
    logic [31:0] lec_log [256];
    logic [5:0]  lc_log  [256];
    logic        rd_pend = 1'b0;
    logic        wlog_pend = 1'b0;
    logic [31:0] rd_addr = 32'h0;
    int          rv_cnt = 0;
    int          wait_cnt = 0;

    always @(negedge clk) begin
        if (reset) begin
            gnt = 1'b0; rvalid = 1'b0; rd_pend = 1'b0; wlog_pend = 1'b0; wait_cnt = 0;
        end else begin
            if (wlog_pend) begin
                lec_log[wr_n] = m_lec;
                lc_log[wr_n]  = m_lc;
                wr_n = wr_n + 1;
                wlog_pend = 1'b0;
            end
            gnt = 1'b0;
            rvalid = 1'b0;
            if (rd_pend) begin
                if (rv_cnt == 0) begin
                    rvalid = 1'b1;
                    rdata = mem[rd_addr[9:2]];
                    rd_pend = 1'b0;
                end else begin
                    rv_cnt = rv_cnt - 1;
                end
            end else if (m_req) begin
                if (wait_cnt == 0) begin
                    gnt = 1'b1;
                    if (m_we) begin
                        wa_log[wr_n] = m_addr;
                        wd_log[wr_n] = m_wdata;
                        wlog_pend = 1'b1;
                    end else begin
                        rd_pend = 1'b1;
                        rd_addr = m_addr;
                        rv_cnt = int'($urandom_range(stall_max, 0));
                    end
                    wait_cnt = int'($urandom_range(stall_max, 0));
                end else begin
                    wait_cnt = wait_cnt - 1;
                end
            end
        end
    end

    task automatic run_job(input int which, input logic [31:0] src, input logic [31:0] dst,
                           input logic [15:0] n, input int limit,
                           output int done_cnt, output int done_cyc, output int busy_cyc,
                           output int req_cyc, output int unstable, output bit timed_out);
        logic        prev_hold;
        logic [31:0] pa, pd;
        logic        pw;
        done_cnt = 0; done_cyc = 0; busy_cyc = 0; req_cyc = 0; unstable = 0;
        prev_hold = 1'b0; pa = 32'h0; pd = 32'h0; pw = 1'b0;
        sel = 2'(which);
        src_base = src; dst_base = dst; num_elems = n;
        @(negedge clk); #1;
        start_v[which] = 1'b1;
        for (int c = 1; c <= limit; c++) begin
            @(negedge clk); #1;
            if (c == 1) start_v = 3'b000;
            if (m_busy) busy_cyc++;
            if (m_req) req_cyc++;
            if (prev_hold && m_req && (m_addr !== pa || m_we !== pw || m_wdata !== pd)) unstable++;
            prev_hold = m_req && !gnt;
            pa = m_addr; pw = m_we; pd = m_wdata;
            if (m_done) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = c;
            end
            if (done_cyc != 0 && c >= done_cyc + 3) break;
        end
        timed_out = (done_cyc == 0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        tests++; if (busy_a[0] !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b expected 0", busy_a[0]); end
        tests++; if (done_a[0] !== 1'b0) begin fails++; $display("FAIL rst_done: got %b expected 0", done_a[0]); end
        tests++; if (req_a[0] !== 1'b0 || we_a[0] !== 1'b0) begin fails++; $display("FAIL rst_req_we: got %b%b expected 00", req_a[0], we_a[0]); end
        tests++; if (addr_a[0] !== 32'h0 || wdata_a[0] !== 32'h0) begin fails++; $display("FAIL rst_addr_wdata: got %h %h expected 0 0", addr_a[0], wdata_a[0]); end
        tests++; if (idx_a[0] !== 16'h0 || lc_a[0] !== 6'h0) begin fails++; $display("FAIL rst_idx_lc: got %0d %0d expected 0 0", idx_a[0], lc_a[0]); end
        tests++; if (lec_a[0] !== 32'h0 || tot_a[0] !== 32'h0) begin fails++; $display("FAIL rst_perf: got %0d %0d expected 0 0", lec_a[0], tot_a[0]); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        tests++; if (busy_a[0] !== 1'b0 || req_a[0] !== 1'b0) begin fails++; $display("FAIL rst_idle: got busy %b req %b expected 0 0", busy_a[0], req_a[0]); end
    endtask

    task automatic test_zero_wait();
        int dc, dcyc, bc, rc, us, base;
        bit to;
        stall_max = 0;
        base = wr_n;
        run_job(0, 32'h100, 32'h150, 16'd20, 2000, dc, dcyc, bc, rc, us, to);
        tests++; if (to) begin fails++; $display("FAIL zw_timeout: got no done expected done"); end
        tests++; if (wr_n - base != 20) begin fails++; $display("FAIL zw_writes: got %0d expected 20", wr_n - base); end
        for (int k = 0; k < 20; k++) begin
            tests++;
            if (wd_log[base+k] !== 32'(exp_cnt[k]) || wa_log[base+k] !== 32'h150 + 32'(4*k) || lec_log[base+k] !== 32'd35) begin
                fails++;
                $display("FAIL zw_elem[%0d]: got cnt %0d addr %h cyc %0d expected cnt %0d addr %h cyc 35",
                         k, wd_log[base+k], wa_log[base+k], lec_log[base+k], exp_cnt[k], 32'h150 + 32'(4*k));
            end
        end
        tests++; if (tot_a[0] !== 32'd700) begin fails++; $display("FAIL zw_total: got %0d expected 700", tot_a[0]); end
        tests++; if (bc != 700) begin fails++; $display("FAIL zw_busy_cycles: got %0d expected 700", bc); end
        tests++; if (dc != 1) begin fails++; $display("FAIL zw_done_pulses: got %0d expected 1", dc); end
        tests++; if (lc_a[0] !== 6'd4) begin fails++; $display("FAIL zw_last_count: got %0d expected 4", lc_a[0]); end
    endtask

    task automatic test_zero_len();
        int dc, dcyc, bc, rc, us;
        bit to;
        run_job(0, 32'h100, 32'h150, 16'd0, 50, dc, dcyc, bc, rc, us, to);
        tests++; if (dcyc != 1) begin fails++; $display("FAIL zl_done_cycle: got %0d expected 1", dcyc); end
        tests++; if (dc != 1) begin fails++; $display("FAIL zl_done_pulses: got %0d expected 1", dc); end
        tests++; if (bc != 0) begin fails++; $display("FAIL zl_busy: got %0d expected 0", bc); end
        tests++; if (rc != 0) begin fails++; $display("FAIL zl_req: got %0d expected 0", rc); end
        tests++; if (tot_a[0] !== 32'd0) begin fails++; $display("FAIL zl_total: got %0d expected 0", tot_a[0]); end
        tests++; if (lc_a[0] !== 6'd4) begin fails++; $display("FAIL zl_last_count_hold: got %0d expected 4", lc_a[0]); end
    endtask

    task automatic test_early_exit();
        int dc, dcyc, bc, rc, us, base;
        bit to;
        int exp_lec [5];
        exp_lec = '{4, 4, 13, 26, 35};
        base = wr_n;
        run_job(1, 32'h100, 32'h200, 16'd20, 2000, dc, dcyc, bc, rc, us, to);
        tests++; if (to || wr_n - base != 20) begin fails++; $display("FAIL ee_writes: got %0d timeout %0d expected 20 0", wr_n - base, to); end
        for (int k = 0; k < 20; k++) begin
            tests++;
            if (wd_log[base+k] !== 32'(exp_cnt[k]) || lc_log[base+k] !== 6'(exp_cnt[k])) begin
                fails++;
                $display("FAIL ee_count[%0d]: got %0d/%0d expected %0d", k, wd_log[base+k], lc_log[base+k], exp_cnt[k]);
            end
        end
        for (int k = 0; k < 5; k++) begin
            tests++;
            if (lec_log[base+k] !== 32'(exp_lec[k])) begin
                fails++;
                $display("FAIL ee_cycles[%0d]: got %0d expected %0d", k, lec_log[base+k], exp_lec[k]);
            end
        end
    endtask

    task automatic test_bpc4();
        int dc, dcyc, bc, rc, us, base;
        bit to;
        base = wr_n;
        run_job(2, 32'h100, 32'h280, 16'd20, 1000, dc, dcyc, bc, rc, us, to);
        tests++; if (to || wr_n - base != 20) begin fails++; $display("FAIL b4_writes: got %0d timeout %0d expected 20 0", wr_n - base, to); end
        for (int k = 0; k < 20; k++) begin
            tests++;
            if (wd_log[base+k] !== 32'(exp_cnt[k]) || lec_log[base+k] !== 32'd11) begin
                fails++;
                $display("FAIL b4_elem[%0d]: got cnt %0d cyc %0d expected cnt %0d cyc 11", k, wd_log[base+k], lec_log[base+k], exp_cnt[k]);
            end
        end
        tests++; if (wd_log[base+9] !== 32'd32) begin fails++; $display("FAIL b4_all_ones: got %0d expected 32", wd_log[base+9]); end
        tests++; if (tot_a[2] !== 32'd220) begin fails++; $display("FAIL b4_total: got %0d expected 220", tot_a[2]); end
    endtask

    task automatic test_stalls();
        int dc, dcyc, bc, rc, us, base;
        bit to;
        stall_max = 5;
        base = wr_n;
        run_job(0, 32'h100, 32'h150, 16'd20, 5000, dc, dcyc, bc, rc, us, to);
        stall_max = 0;
        tests++; if (to || wr_n - base != 20) begin fails++; $display("FAIL st_writes: got %0d timeout %0d expected 20 0", wr_n - base, to); end
        for (int k = 0; k < 20; k++) begin
            tests++;
            if (wd_log[base+k] !== 32'(exp_cnt[k]) || wa_log[base+k] !== 32'h150 + 32'(4*k)) begin
                fails++;
                $display("FAIL st_elem[%0d]: got cnt %0d addr %h expected cnt %0d addr %h",
                         k, wd_log[base+k], wa_log[base+k], exp_cnt[k], 32'h150 + 32'(4*k));
            end
        end
        tests++; if (us != 0) begin fails++; $display("FAIL st_stable: got %0d changes expected 0", us); end
        tests++; if (dc != 1) begin fails++; $display("FAIL st_done_pulses: got %0d expected 1", dc); end
        tests++; if (tot_a[0] !== 32'(bc)) begin fails++; $display("FAIL st_total: got %0d expected %0d", tot_a[0], bc); end
    endtask

    task automatic test_reset_abort();
        int dc, dcyc, bc, rc, us, base, snap, reqs;
        bit to, seen;
        stall_max = 0;
        sel = 2'd0;
        src_base = 32'h100; dst_base = 32'h150; num_elems = 16'd20;
        @(negedge clk); #1;
        start_v[0] = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk); #1;
            start_v = 3'b000;
            if (idx_a[0] == 16'd5) begin seen = 1'b1; break; end
        end
        tests++; if (!seen) begin fails++; $display("FAIL ra_reach_elem5: got timeout expected elem_idx 5"); end
        repeat (5) @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        tests++; if (busy_a[0] !== 1'b0 || req_a[0] !== 1'b0 || idx_a[0] !== 16'h0) begin
            fails++; $display("FAIL ra_async: got busy %b req %b idx %0d expected 0 0 0", busy_a[0], req_a[0], idx_a[0]);
        end
        repeat (2) @(negedge clk);
        #1;
        reset = 1'b0;
        snap = wr_n;
        reqs = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); #1;
            if (req_a[0]) reqs++;
        end
        tests++; if (reqs != 0 || wr_n != snap) begin fails++; $display("FAIL ra_quiet: got req %0d writes %0d expected 0 0", reqs, wr_n - snap); end
        base = wr_n;
        run_job(0, 32'h100, 32'h300, 16'd3, 500, dc, dcyc, bc, rc, us, to);
        tests++; if (to || wr_n - base != 3) begin fails++; $display("FAIL ra_writes: got %0d timeout %0d expected 3 0", wr_n - base, to); end
        for (int k = 0; k < 3; k++) begin
            tests++;
            if (wd_log[base+k] !== 32'(exp_cnt[k]) || wa_log[base+k] !== 32'h300 + 32'(4*k)) begin
                fails++;
                $display("FAIL ra_elem[%0d]: got cnt %0d addr %h expected cnt %0d addr %h",
                         k, wd_log[base+k], wa_log[base+k], exp_cnt[k], 32'h300 + 32'(4*k));
            end
        end
    endtask

    initial begin
        src_words = '{32'h0, 32'h1, 32'h200, 32'h400000, 32'h80000000, 32'h51C06460, 32'hDEC287D9,
                      32'h6C896594, 32'h99999999, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'hFFFFFFFE, 32'hC7B52169,
                      32'h8CEFF731, 32'hA550921E, 32'h0DB01F33, 32'h24BB7B48, 32'h98513914, 32'hCD76ED30,
                      32'hC0000003};
        exp_cnt = '{0, 1, 1, 1, 1, 10, 18, 14, 16, 32, 31, 31, 16, 20, 13, 15, 16, 12, 18, 4};
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        for (int i = 0; i < 20; i++) mem[64+i] = src_words[i];
        test_reset();
        test_zero_wait();
        test_zero_len();
        test_early_exit();
        test_bpc4();
        test_stalls();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
